// File: rtl/sram_responder.sv
// SRAM device responder: fixed-latency reads and writes behind ce/wr/oe strobes,
// with protocol violation detection and a fully cleared array on reset.
module sram_responder #(
  parameter int unsigned RD_CYCLES     = 10,
  parameter int unsigned WR_CYCLES     = 10,
  parameter int unsigned CNT_REG_WIDTH = 5,
  parameter int unsigned ADDR_WIDTH    = 4,
  parameter int unsigned DATA_WIDTH    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  wr,
  input  logic                  oe,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rdata_valid,
  output logic                  wr_ack,
  output logic                  violation,
  output logic                  busy
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam logic [CNT_REG_WIDTH-1:0] RD_LOAD = CNT_REG_WIDTH'(RD_CYCLES - 1);
  localparam logic [CNT_REG_WIDTH-1:0] WR_LOAD = CNT_REG_WIDTH'(WR_CYCLES - 1);
  localparam logic [CNT_REG_WIDTH-1:0] CNT_ONE = CNT_REG_WIDTH'(1);

  typedef enum logic [2:0] {
    IDLE,
    RD_ACCESS,
    RD_DRIVE,
    WR_ACCESS,
    WR_COMMIT
  } state_e;

  state_e                  state_q;
  logic [CNT_REG_WIDTH-1:0] cnt_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic                    rvalid_q;
  logic                    wr_ack_q;
  logic                    viol_q;
  logic                    busy_q;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

  logic rd_req, wr_req, both_req, rd_abort, wr_abort, cnt_zero;

  assign rd_req   = ce & oe & ~wr;
  assign wr_req   = ce & wr & ~oe;
  assign both_req = ce & wr & oe;
  assign rd_abort = ~ce | ~oe | wr | (addr != addr_q);
  assign wr_abort = ~ce | ~wr | oe | (addr != addr_q);
  assign cnt_zero = (cnt_q == '0);

  // Abort is tested before completion so a same-edge abort always wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      wr_ack_q <= 1'b0;
      viol_q   <= 1'b0;
      busy_q   <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[ADDR_WIDTH'(i)] <= '0;
      end
    end else begin
      wr_ack_q <= 1'b0;
      viol_q   <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (both_req) begin
            viol_q <= 1'b1;
          end else if (rd_req) begin
            addr_q  <= addr;
            cnt_q   <= RD_LOAD;
            state_q <= RD_ACCESS;
            busy_q  <= 1'b1;
          end else if (wr_req) begin
            addr_q  <= addr;
            cnt_q   <= WR_LOAD;
            state_q <= WR_ACCESS;
            busy_q  <= 1'b1;
          end
        end
        RD_ACCESS: begin
          if (rd_abort) begin
            viol_q  <= 1'b1;
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (cnt_zero) begin
            rdata_q  <= mem_q[addr_q];
            rvalid_q <= 1'b1;
            state_q  <= RD_DRIVE;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        RD_DRIVE: begin
          if (!(ce && oe)) begin
            rvalid_q <= 1'b0;
            state_q  <= IDLE;
            busy_q   <= 1'b0;
          end
        end
        WR_ACCESS: begin
          if (wr_abort) begin
            viol_q  <= 1'b1;
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (cnt_zero) begin
            mem_q[addr_q] <= wdata;
            wr_ack_q      <= 1'b1;
            state_q       <= WR_COMMIT;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        WR_COMMIT: begin
          if (!(ce && wr)) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign rdata       = rdata_q;
  assign rdata_valid = rvalid_q;
  assign wr_ack      = wr_ack_q;
  assign violation   = viol_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_sram_responder.sv
// Bench for sram_responder: directed protocol scenarios followed by random
// reads, writes and aborts checked against an array model of the memory.
module tb_sram_responder;

  localparam int unsigned RDC = 3;
  localparam int unsigned WRC = 3;
  localparam int unsigned AW  = 4;
  localparam int unsigned DW  = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          ce, wr, oe;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;
  logic          rdata_valid, wr_ack, violation, busy;

  int total = 0;
  int bad   = 0;
  logic [DW-1:0] model [16];
  logic [DW-1:0] last_rd;

  always #5 clk = ~clk;

  sram_responder #(
    .RD_CYCLES    (RDC),
    .WR_CYCLES    (WRC),
    .CNT_REG_WIDTH(5),
    .ADDR_WIDTH   (AW),
    .DATA_WIDTH   (DW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .ce         (ce),
    .wr         (wr),
    .oe         (oe),
    .addr       (addr),
    .wdata      (wdata),
    .rdata      (rdata),
    .rdata_valid(rdata_valid),
    .wr_ack     (wr_ack),
    .violation  (violation),
    .busy       (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus;
    ce = 1'b0; wr = 1'b0; oe = 1'b0;
  endtask

  task automatic do_read(input logic [AW-1:0] a, input string t);
    ce = 1'b1; oe = 1'b1; wr = 1'b0; addr = a;
    tick;
    chk({t, "/acc_busy"}, busy, 1);
    chk({t, "/acc_valid"}, rdata_valid, 0);
    for (int k = 1; k < RDC; k++) begin
      tick;
      chk({t, "/wait_valid"}, rdata_valid, 0);
      chk({t, "/wait_busy"}, busy, 1);
    end
    tick;
    chk({t, "/valid"}, rdata_valid, 1);
    chk({t, "/data"}, rdata, model[a]);
    tick;
    chk({t, "/hold_valid"}, rdata_valid, 1);
    chk({t, "/hold_busy"}, busy, 1);
    idle_bus;
    tick;
    chk({t, "/drop_valid"}, rdata_valid, 0);
    chk({t, "/drop_busy"}, busy, 0);
    chk({t, "/keep_data"}, rdata, model[a]);
    last_rd = model[a];
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input string t);
    ce = 1'b1; wr = 1'b1; oe = 1'b0; addr = a; wdata = ~d;
    tick;
    chk({t, "/acc_busy"}, busy, 1);
    chk({t, "/acc_ack"}, wr_ack, 0);
    for (int k = 1; k < WRC; k++) begin
      tick;
      chk({t, "/wait_ack"}, wr_ack, 0);
    end
    wdata = d;  // data only has to be valid on the completing edge
    tick;
    chk({t, "/ack"}, wr_ack, 1);
    chk({t, "/ack_viol"}, violation, 0);
    model[a] = d;
    tick;
    chk({t, "/ack_pulse"}, wr_ack, 0);
    chk({t, "/commit_busy"}, busy, 1);
    idle_bus;
    tick;
    chk({t, "/drop_busy"}, busy, 0);
  endtask

  // Drop wr just before edge k after acceptance (k == WRC collides with completion).
  task automatic write_abort(input logic [AW-1:0] a, input logic [DW-1:0] d,
                             input int k, input string t);
    ce = 1'b1; wr = 1'b1; oe = 1'b0; addr = a; wdata = d;
    tick;
    for (int j = 1; j < k; j++) begin
      tick;
      chk({t, "/wait_ack"}, wr_ack, 0);
    end
    wr = 1'b0;
    tick;
    chk({t, "/viol"}, violation, 1);
    chk({t, "/no_ack"}, wr_ack, 0);
    chk({t, "/busy"}, busy, 0);
    idle_bus;
    tick;
    chk({t, "/viol_pulse"}, violation, 0);
  endtask

  task automatic read_abort(input logic [AW-1:0] a, input logic [AW-1:0] b,
                            input int k, input string t);
    ce = 1'b1; oe = 1'b1; wr = 1'b0; addr = a;
    tick;
    for (int j = 1; j < k; j++) begin
      tick;
      chk({t, "/wait_valid"}, rdata_valid, 0);
    end
    addr = b;
    tick;
    chk({t, "/viol"}, violation, 1);
    chk({t, "/valid"}, rdata_valid, 0);
    chk({t, "/busy"}, busy, 0);
    chk({t, "/rdata_kept"}, rdata, last_rd);
    idle_bus;
    tick;
    chk({t, "/viol_pulse"}, violation, 0);
    chk({t, "/idle_busy"}, busy, 0);
  endtask

  initial begin
    logic [AW-1:0] ra, rb;
    logic [DW-1:0] rd;
    int            op;

    for (int i = 0; i < 16; i++) model[i] = '0;
    last_rd = '0;
    reset = 1'b1;
    idle_bus;
    addr = '0; wdata = '0;
    #12;
    chk("rst/busy", busy, 0);
    chk("rst/rdata", rdata, 0);
    chk("rst/valid", rdata_valid, 0);
    chk("rst/ack", wr_ack, 0);
    chk("rst/viol", violation, 0);
    reset = 1'b0;
    tick;

    do_read(4'd5, "rd5");
    do_write(4'd9, 16'hA5C3, "wr9");
    do_read(4'd9, "rd9");
    write_abort(4'd2, 16'h1234, 1, "wab2");
    do_read(4'd2, "rd2");
    read_abort(4'd4, 4'd6, 2, "rab4");

    ce = 1'b1; wr = 1'b1; oe = 1'b1;
    tick;
    chk("both/viol", violation, 1);
    chk("both/busy", busy, 0);
    ce = 1'b0;
    tick;
    chk("noce/viol", violation, 0);
    chk("noce/busy", busy, 0);
    ce = 1'b1; wr = 1'b0; oe = 1'b0;
    tick;
    chk("ceonly/busy", busy, 0);
    idle_bus;

    ce = 1'b1; wr = 1'b1; oe = 1'b0; addr = 4'd7; wdata = 16'hBEEF;
    tick;
    tick;
    #2;
    reset = 1'b1;
    #1;
    chk("midrst/busy", busy, 0);
    chk("midrst/ack", wr_ack, 0);
    chk("midrst/viol", violation, 0);
    chk("midrst/rdata", rdata, 0);
    for (int i = 0; i < 16; i++) model[i] = '0;
    last_rd = '0;
    tick;
    tick;
    reset = 1'b0;
    tick;
    chk("postrst/ack", wr_ack, 0);
    chk("postrst/viol", violation, 0);
    idle_bus;
    tick;
    do_read(4'd7, "rd7");
    do_read(4'd9, "rd9_cleared");

    do_write(4'd15, 16'hFFFF, "wr15");
    do_write(4'd0, 16'h0001, "wr0");
    do_read(4'd15, "rd15");
    do_read(4'd0, "rd0");

    write_abort(4'd3, 16'h5A5A, WRC, "wab_same_edge");
    read_abort(4'd8, 4'd9, RDC, "rab_same_edge");
    do_read(4'd3, "rd3");

    for (int n = 0; n < 40; n++) begin
      op = int'($urandom_range(0, 3));
      ra = AW'($urandom_range(0, 15));
      rd = DW'($urandom);
      case (op)
        0: do_read(ra, "rnd_rd");
        1: do_write(ra, rd, "rnd_wr");
        2: write_abort(ra, rd, int'($urandom_range(1, WRC)), "rnd_wab");
        default: begin
          rb = ra ^ AW'($urandom_range(1, 15));
          read_abort(ra, rb, int'($urandom_range(1, RDC)), "rnd_rab");
        end
      endcase
    end
    for (int i = 0; i < 16; i++) do_read(AW'(i), "sweep");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sram_responder.md
SRAM_RESPONDER -- requirements
Module: sram_responder

Interface
REQ-001 SHALL have parameter RD_CYCLES, default 10: clock edges from the accepted read request to read data valid (legal range 1..2^CNT_REG_WIDTH-1).
REQ-002 SHALL have parameter WR_CYCLES, default 10: clock edges from the accepted write request to the array update (legal range 1..2^CNT_REG_WIDTH-1).
REQ-003 SHALL have parameter CNT_REG_WIDTH, default 5: width of the access counter.
REQ-004 SHALL have parameter ADDR_WIDTH, default 4: address width; array depth is 2^ADDR_WIDTH.
REQ-005 SHALL have parameter DATA_WIDTH, default 16: data word width.
REQ-006 SHALL have port clk, input, 1: the only clock; all state updates on the rising edge.
REQ-007 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-008 SHALL have port ce, input, 1: chip enable from the controller, active-high.
REQ-009 SHALL have port wr, input, 1: write strobe, active-high.
REQ-010 SHALL have port oe, input, 1: output enable (read strobe), active-high.
REQ-011 SHALL have port addr, input, ADDR_WIDTH: word address.
REQ-012 SHALL have port wdata, input, DATA_WIDTH: write data.
REQ-013 SHALL have port rdata, output, DATA_WIDTH: registered read data.
REQ-014 SHALL have port rdata_valid, output, 1: rdata holds the requested word.
REQ-015 SHALL have port wr_ack, output, 1: one-cycle pulse on array update.
REQ-016 SHALL have port violation, output, 1: one-cycle pulse on a protocol error.
REQ-017 SHALL have port busy, output, 1: high in any state other than IDLE.

Function
REQ-018 SHALL implement states IDLE, RD_ACCESS, RD_DRIVE, WR_ACCESS, WR_COMMIT.
REQ-019 IDLE, ce&oe&!wr sampled: SHALL latch addr, load counter with RD_CYCLES-1, go to RD_ACCESS.
REQ-020 IDLE, ce&wr&!oe sampled: SHALL latch addr, load counter with WR_CYCLES-1, go to WR_ACCESS.
REQ-021 IDLE, ce&wr&oe: SHALL pulse violation, stay IDLE, and leave array and rdata unchanged; ce alone or strobes without ce SHALL be ignored.
REQ-022 RD_ACCESS and WR_ACCESS: counter SHALL decrement by 1 per edge while nonzero; counter arithmetic is unsigned CNT_REG_WIDTH bits and SHALL never wrap below 0.
REQ-023 RD_ACCESS, counter==0 with strobes held: SHALL load rdata from the array at the latched address, set rdata_valid, go to RD_DRIVE; rdata_valid rises exactly RD_CYCLES edges after the accepting edge.
REQ-024 RD_DRIVE: SHALL hold rdata and rdata_valid while ce&oe; when ce or oe drops, SHALL clear rdata_valid on that edge and go to IDLE; rdata keeps its last value.
REQ-025 WR_ACCESS, counter==0 with strobes held: SHALL write wdata sampled on that edge to the latched address, pulse wr_ack, go to WR_COMMIT.
REQ-026 WR_COMMIT: SHALL stay until wr or ce drops, then go to IDLE; no further writes occur.
REQ-027 In RD_ACCESS, if ce or oe drops, wr rises, or addr differs from the latched address before completion: SHALL pulse violation, not update rdata, go to IDLE.
REQ-028 In WR_ACCESS, if ce or wr drops, oe rises, or addr differs from the latched address before completion: SHALL pulse violation, not write the array, go to IDLE.
REQ-029 An abort and completion on the same edge SHALL resolve as abort.
REQ-030 A new request SHALL be accepted no earlier than the first edge in IDLE; back-to-back accesses cost one IDLE cycle.
REQ-031 Address wrap is not applicable: addr indexes the array directly, all 2^ADDR_WIDTH words legal.

Reset
REQ-032 reset SHALL immediately force state IDLE, counter 0, rdata 0, rdata_valid 0, wr_ack 0, violation 0, busy 0, independent of clk.
REQ-033 reset SHALL clear every array word to 0.
REQ-034 reset asserted mid-access SHALL abandon the access with no array write and no wr_ack/violation pulse.

Verification
REQ-035 Reset, then read addr 5 with RD_CYCLES=3 -> rdata_valid rises 3 edges after acceptance, rdata=0x0000, busy=1 from acceptance until strobe drop.
REQ-036 Write 0xA5C3 to addr 9 (WR_CYCLES=3), drop wr, read addr 9 -> wr_ack one cycle at edge 3; read returns 0xA5C3.
REQ-037 Write 0x1234 to addr 2, drop wr after 1 edge -> violation pulse, no wr_ack; read addr 2 returns 0x0000.
REQ-038 Read addr 4 and change addr to 6 mid-access -> violation pulse, rdata_valid stays 0, state returns IDLE.
REQ-039 ce&wr&oe in IDLE -> violation pulse, busy stays 0; assert reset during WR_ACCESS to addr 7 -> outputs 0 at once, later read of addr 7 returns 0x0000.
REQ-040 Write 0xFFFF to addr 15 and 0x0001 to addr 0 back-to-back -> both wr_acks separated by at least one IDLE cycle; reads return each value.
